// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for rvx10p: load-use bubble, branch/jump flush, downstream hold.
// Optional IDEX_PERF_CNT_EN adds saturating bubble_cnt / flush_cnt counters.
module id_ex_stage #(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            valid_d,
  input  logic            regwrite_d,
  input  logic            memtoreg_d,
  input  logic            memwrite_d,
  input  logic            branch_d,
  input  logic            alusrc_d,
  input  logic            jump_d,
  input  logic [1:0]      aluop_d,
  input  logic [REGW-1:0] rs1_d,
  input  logic [REGW-1:0] rs2_d,
  input  logic [REGW-1:0] rd_d,
  input  logic [XLEN-1:0] rd1_d,
  input  logic [XLEN-1:0] rd2_d,
  input  logic [XLEN-1:0] immext_d,
  input  logic [XLEN-1:0] pc_d,
  input  logic [XLEN-1:0] pcplus4_d,
  input  logic            pcsrc_e,
  input  logic            hold,
  output logic            valid_e,
  output logic            regwrite_e,
  output logic            memtoreg_e,
  output logic            memwrite_e,
  output logic            branch_e,
  output logic            alusrc_e,
  output logic            jump_e,
  output logic [1:0]      aluop_e,
  output logic [REGW-1:0] rs1_e,
  output logic [REGW-1:0] rs2_e,
  output logic [REGW-1:0] rd_e,
  output logic [XLEN-1:0] rd1_e,
  output logic [XLEN-1:0] rd2_e,
  output logic [XLEN-1:0] immext_e,
  output logic [XLEN-1:0] pc_e,
  output logic [XLEN-1:0] pcplus4_e,
`ifdef IDEX_PERF_CNT_EN
  output logic [31:0]     bubble_cnt,
  output logic [31:0]     flush_cnt,
`endif
  output logic            stall_f,
  output logic            stall_d,
  output logic            flush_d
);

  typedef struct packed {
    logic            valid;
    logic            regwrite;
    logic            memtoreg;
    logic            memwrite;
    logic            branch;
    logic            alusrc;
    logic            jump;
    logic [1:0]      aluop;
    logic [REGW-1:0] rs1;
    logic [REGW-1:0] rs2;
    logic [REGW-1:0] rd;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcplus4;
  } idex_t;

  idex_t d_in, e_q;
  logic  uses_rs1, uses_rs2, lwstall;

  always_comb begin
    d_in          = '0;
    d_in.valid    = valid_d;
    d_in.regwrite = regwrite_d & valid_d;
    d_in.memtoreg = memtoreg_d;
    d_in.memwrite = memwrite_d & valid_d;
    d_in.branch   = branch_d;
    d_in.alusrc   = alusrc_d;
    d_in.jump     = jump_d;
    d_in.aluop    = aluop_d;
    d_in.rs1      = rs1_d;
    d_in.rs2      = rs2_d;
    d_in.rd       = rd_d;
    d_in.rd1      = rd1_d;
    d_in.rd2      = rd2_d;
    d_in.imm      = immext_d;
    d_in.pc       = pc_d;
    d_in.pcplus4  = pcplus4_d;
  end

  // Stores still read rs2 even though the ALU takes the immediate.
  assign uses_rs1 = ~jump_d;
  assign uses_rs2 = ~alusrc_d | memwrite_d;
  assign lwstall  = e_q.valid & e_q.memtoreg & (e_q.rd != '0) & valid_d &
                    ((uses_rs1 & (rs1_d == e_q.rd)) | (uses_rs2 & (rs2_d == e_q.rd)));

  // Gated by reset_n so a held/flushing neighbour can't stall us while in reset.
  assign stall_f = (lwstall | hold) & ~pcsrc_e & reset_n;
  assign stall_d = stall_f;
  assign flush_d = pcsrc_e & reset_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     e_q <= '0;
    else if (pcsrc_e) e_q <= '0;
    else if (!hold)   e_q <= lwstall ? '0 : d_in;
  end

  assign valid_e    = e_q.valid;
  assign regwrite_e = e_q.regwrite;
  assign memtoreg_e = e_q.memtoreg;
  assign memwrite_e = e_q.memwrite;
  assign branch_e   = e_q.branch;
  assign alusrc_e   = e_q.alusrc;
  assign jump_e     = e_q.jump;
  assign aluop_e    = e_q.aluop;
  assign rs1_e      = e_q.rs1;
  assign rs2_e      = e_q.rs2;
  assign rd_e       = e_q.rd;
  assign rd1_e      = e_q.rd1;
  assign rd2_e      = e_q.rd2;
  assign immext_e   = e_q.imm;
  assign pc_e       = e_q.pc;
  assign pcplus4_e  = e_q.pcplus4;

`ifdef IDEX_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (pcsrc_e && flush_cnt != 32'hFFFF_FFFF) flush_cnt <= flush_cnt + 32'd1;
      if (!pcsrc_e && !hold && lwstall && bubble_cnt != 32'hFFFF_FFFF)
        bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized + directed bench for id_ex_stage against a cycle-level behavioural model.
module tb_id_ex_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        valid_d, regwrite_d, memtoreg_d, memwrite_d, branch_d, alusrc_d, jump_d;
  logic [1:0]  aluop_d;
  logic [4:0]  rs1_d, rs2_d, rd_d;
  logic [31:0] rd1_d, rd2_d, immext_d, pc_d, pcplus4_d;
  logic        pcsrc_e, hold;
  logic        valid_e, regwrite_e, memtoreg_e, memwrite_e, branch_e, alusrc_e, jump_e;
  logic [1:0]  aluop_e;
  logic [4:0]  rs1_e, rs2_e, rd_e;
  logic [31:0] rd1_e, rd2_e, immext_e, pc_e, pcplus4_e;
  logic        stall_f, stall_d, flush_d;
`ifdef IDEX_PERF_CNT_EN
  logic [31:0] bubble_cnt, flush_cnt;
`endif

  id_ex_stage #(.XLEN(32), .REGW(5)) dut (
    .clk(clk), .reset_n(reset_n), .valid_d(valid_d), .regwrite_d(regwrite_d),
    .memtoreg_d(memtoreg_d), .memwrite_d(memwrite_d), .branch_d(branch_d),
    .alusrc_d(alusrc_d), .jump_d(jump_d), .aluop_d(aluop_d), .rs1_d(rs1_d),
    .rs2_d(rs2_d), .rd_d(rd_d), .rd1_d(rd1_d), .rd2_d(rd2_d), .immext_d(immext_d),
    .pc_d(pc_d), .pcplus4_d(pcplus4_d), .pcsrc_e(pcsrc_e), .hold(hold),
    .valid_e(valid_e), .regwrite_e(regwrite_e), .memtoreg_e(memtoreg_e),
    .memwrite_e(memwrite_e), .branch_e(branch_e), .alusrc_e(alusrc_e),
    .jump_e(jump_e), .aluop_e(aluop_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .rd1_e(rd1_e), .rd2_e(rd2_e), .immext_e(immext_e), .pc_e(pc_e),
    .pcplus4_e(pcplus4_e),
`ifdef IDEX_PERF_CNT_EN
    .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt),
`endif
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected execute-stage contents: a record of what instruction sits in E.
  logic        m_valid, m_rw, m_mtr, m_mw, m_br, m_as, m_j;
  logic [1:0]  m_op;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [31:0] m_rd1, m_rd2, m_imm, m_pc, m_pc4;
  logic [31:0] m_bub, m_fl;

  task automatic m_clear(input logic counters);
    {m_valid, m_rw, m_mtr, m_mw, m_br, m_as, m_j} = '0;
    m_op = '0; m_rs1 = '0; m_rs2 = '0; m_rd = '0;
    m_rd1 = '0; m_rd2 = '0; m_imm = '0; m_pc = '0; m_pc4 = '0;
    if (counters) begin m_bub = '0; m_fl = '0; end
  endtask

  function automatic logic m_loaduse();
    logic reads1, reads2;
    reads1 = (jump_d == 1'b0) && rs1_d == m_rd;
    reads2 = (alusrc_d == 1'b0 || memwrite_d == 1'b1) && rs2_d == m_rd;
    return m_valid && m_mtr && m_rd != 0 && valid_d && (reads1 || reads2);
  endfunction

  task automatic check_e();
    chk("valid_e", valid_e, m_valid);       chk("regwrite_e", regwrite_e, m_rw);
    chk("memtoreg_e", memtoreg_e, m_mtr);   chk("memwrite_e", memwrite_e, m_mw);
    chk("branch_e", branch_e, m_br);        chk("alusrc_e", alusrc_e, m_as);
    chk("jump_e", jump_e, m_j);             chk("aluop_e", aluop_e, m_op);
    chk("rs1_e", rs1_e, m_rs1);             chk("rs2_e", rs2_e, m_rs2);
    chk("rd_e", rd_e, m_rd);                chk("rd1_e", rd1_e, m_rd1);
    chk("rd2_e", rd2_e, m_rd2);             chk("immext_e", immext_e, m_imm);
    chk("pc_e", pc_e, m_pc);                chk("pcplus4_e", pcplus4_e, m_pc4);
`ifdef IDEX_PERF_CNT_EN
    chk("bubble_cnt", bubble_cnt, m_bub);   chk("flush_cnt", flush_cnt, m_fl);
`endif
  endtask

  task automatic drive(input logic v, rw, mtr, mw, br, as, j, input logic [1:0] op,
                       input logic [4:0] s1, s2, d, input logic ps, hl);
    valid_d = v; regwrite_d = rw; memtoreg_d = mtr; memwrite_d = mw;
    branch_d = br; alusrc_d = as; jump_d = j; aluop_d = op;
    rs1_d = s1; rs2_d = s2; rd_d = d; pcsrc_e = ps; hold = hl;
    rd1_d = $urandom; rd2_d = $urandom; immext_d = $urandom;
    pc_d = $urandom & 32'hFFFF_FFFC; pcplus4_d = pc_d + 32'd4;
  endtask

  // Called at posedge+1: check combinational outputs, advance model over the edge, check E.
  task automatic step();
    logic lu, st;
    @(negedge clk);
    lu = m_loaduse();
    st = (lu || hold) && !pcsrc_e;
    chk("stall_f", stall_f, st);
    chk("stall_d", stall_d, st);
    chk("flush_d", flush_d, pcsrc_e);
    @(posedge clk);
    if (pcsrc_e) begin
      m_clear(1'b0);
      if (m_fl != 32'hFFFF_FFFF) m_fl++;
    end else if (!hold) begin
      if (lu) begin
        m_clear(1'b0);
        if (m_bub != 32'hFFFF_FFFF) m_bub++;
      end else begin
        m_valid = valid_d; m_rw = regwrite_d && valid_d; m_mtr = memtoreg_d;
        m_mw = memwrite_d && valid_d; m_br = branch_d; m_as = alusrc_d; m_j = jump_d;
        m_op = aluop_d; m_rs1 = rs1_d; m_rs2 = rs2_d; m_rd = rd_d;
        m_rd1 = rd1_d; m_rd2 = rd2_d; m_imm = immext_d; m_pc = pc_d; m_pc4 = pcplus4_d;
      end
    end
    #1 check_e();
  endtask

  // lw xd, 0(x1) / add xd, xa, xb
  task automatic lw_instr(input logic [4:0] d, input logic ps);
    drive(1, 1, 1, 0, 0, 1, 0, 2'b00, 5'd1, 5'd0, d, ps, 0);
  endtask
  task automatic add_instr(input logic [4:0] a, b, d, input logic ps);
    drive(1, 1, 0, 0, 0, 0, 0, 2'b10, a, b, d, ps, 0);
  endtask

  initial begin
    m_clear(1'b1);
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 2'b00, 5'd0, 5'd0, 5'd0, 1, 1);
    #12;
    chk("rst_stall_f", stall_f, 1'b0);
    chk("rst_flush_d", flush_d, 1'b0);
    check_e();
    pcsrc_e = 1'b0; hold = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;

    // straight-line add x3,x1,x2
    add_instr(5'd1, 5'd2, 5'd3, 0);
    step();
    chk("add_rd_e", rd_e, 32'd3);
    chk("add_aluop_e", aluop_e, 32'd2);

    // two load-use bubbles: lw x5 then add x6,x5,x7
    for (int k = 0; k < 2; k++) begin
      lw_instr(5'd5, 0); step();
      add_instr(5'd5, 5'd7, 5'd6, 0);
      #2 chk("lu_stall_f", stall_f, 1'b1);
      step();
      chk("lu_bubble_valid", valid_e, 1'b0);
      step();
      chk("lu_capture_rs1", rs1_e, 32'd5);
    end

    // lw x0 then read x0: no stall
    lw_instr(5'd0, 0); step();
    add_instr(5'd0, 5'd0, 5'd6, 0);
    #2 chk("x0_no_stall", stall_f, 1'b0);
    step();
    // lw x4 then addi x8,x9,4 with rs2 field=4: rs2 unused
    lw_instr(5'd4, 0); step();
    drive(1, 1, 0, 0, 0, 1, 0, 2'b00, 5'd9, 5'd4, 5'd8, 0, 0);
    #2 chk("imm_no_stall", stall_f, 1'b0);
    step();

    // flush beats load-use
    lw_instr(5'd5, 0); step();
    drive(1, 0, 0, 1, 0, 1, 0, 2'b00, 5'd5, 5'd5, 5'd0, 1, 0);
    #2 chk("fl_stall_d", stall_d, 1'b0);
    chk("fl_flush_d", flush_d, 1'b1);
    step();
    chk("fl_valid_e", valid_e, 1'b0);
    chk("fl_memwrite_e", memwrite_e, 1'b0);
`ifdef IDEX_PERF_CNT_EN
    chk("dir_bubble_cnt", bubble_cnt, 32'd2);
    chk("dir_flush_cnt", flush_cnt, 32'd1);
`endif

    // hold for 3 cycles with changing decode inputs
    add_instr(5'd1, 5'd2, 5'd10, 0); step();
    for (int k = 0; k < 3; k++) begin
      add_instr(5'(k + 11), 5'd2, 5'(k + 20), 0);
      hold = 1'b1;
      #2 chk("hold_stall_f", stall_f, 1'b1);
      step();
      chk("hold_rd_e", rd_e, 32'd10);
    end
    add_instr(5'd3, 5'd4, 5'd25, 0); step();
    chk("unhold_rd_e", rd_e, 32'd25);

    // asynchronous reset mid-cycle while valid_e=1
    #2 reset_n = 1'b0;
    #1 chk("async_valid_e", valid_e, 1'b0);
    m_clear(1'b1);
    check_e();
    @(posedge clk); #1 reset_n = 1'b1;
    add_instr(5'd1, 5'd2, 5'd7, 0); step();
    chk("post_rst_rd_e", rd_e, 32'd7);

    // randomized traffic on a small register window so hazards are frequent
    for (int n = 0; n < 500; n++) begin
      drive($urandom_range(0, 7) != 0, 1'($urandom), 1'($urandom_range(0, 2) == 0),
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
            2'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
